// File: rtl/core_pipe_pkg.sv
// Shared types and constants for the Selen pipeline sequencer.
//   pipe_state_e : sequencer FSM states (RUN, LSU_WAIT, DROP)
//   HAZ_*_BIT    : bit positions inside dec_haz_cmd
//   PERF_W_DEF   : default width of the performance counters
//   src_hit()    : one source-operand versus destination match
package core_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LSU_WAIT = 2'd1,
    ST_DROP     = 2'd2
  } pipe_state_e;

  localparam int HAZ_RS1_BIT = 0;
  localparam int HAZ_RS2_BIT = 1;

  localparam int PERF_W_DEF = 32;

  // A source only counts as a hazard if the instruction actually reads it.
  function automatic logic src_hit(input logic       used,
                                   input logic [4:0] src,
                                   input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/core_luse_det.sv
// Load-use hazard comparator between the DEC sources and the EXE load.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides what a hazard stalls.
// Ports:
//   haz_cmd   in  2  source use of the DEC instruction (bit0 rs1, bit1 rs2)
//   rs1, rs2  in  5  DEC source registers
//   exe_rd    in  5  EXE destination register
//   exe_ld    in  1  EXE instruction is a load
//   exe_val   in  1  EXE holds a valid instruction
//   hazard    out 1  DEC must wait one cycle for the load data
module core_luse_det
  import core_pipe_pkg::*;
(
  input  logic [1:0] haz_cmd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] exe_rd,
  input  logic       exe_ld,
  input  logic       exe_val,
  output logic       hazard
);

  logic ld_live;
  logic any_hit;

  // x0 is hardwired to zero, so a load "into" x0 never creates a dependency.
  assign ld_live = exe_val & exe_ld & (exe_rd != 5'd0);

  assign any_hit = src_hit(haz_cmd[HAZ_RS1_BIT], rs1, exe_rd) |
                   src_hit(haz_cmd[HAZ_RS2_BIT], rs2, exe_rd);

  assign hazard = ld_live & any_hit;

endmodule

// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencer for the five-stage Selen core: stage enables, bubble kills, redirect drop tracking.
// Latency: control outputs are combinational from state and inputs; state and counters move on posedge clk.
// Backpressure: an outstanding l1d request freezes every stage; fetch stalls and load-use insert bubbles.
// Optional feature: define CORE_PIPE_CTRL_PERF_EN to build the four saturating performance counters;
// otherwise the counter outputs are tied to zero and no counter flops exist.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   l1i_ack_in, l1i_busy_in  fetch response valid / fetch request outstanding
//   dec_haz_cmd_in, dec_rs1_in, dec_rs2_in      DEC source usage and registers
//   exe_val_in, exe_ld_in, exe_rd_in, exe_br_taken_in  EXE instruction info
//   mem_l1d_req_val_in, mem_l1d_ack_in          MEM data-cache handshake
//   *_enb_out                stage register enables (IF, DEC, EXE, MEM, WB)
//   if_kill_out, dec_kill_out  clear IF/DEC and DEC/EXE registers
//   state_out                current FSM state
//   perf_*_cnt_out           fetch-stall, load-use, lsu-wait and flush counters
module core_pipe_ctrl
  import core_pipe_pkg::*;
#(
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l1i_ack_in,
  input  logic              l1i_busy_in,
  input  logic [1:0]        dec_haz_cmd_in,
  input  logic [4:0]        dec_rs1_in,
  input  logic [4:0]        dec_rs2_in,
  input  logic              exe_val_in,
  input  logic              exe_ld_in,
  input  logic [4:0]        exe_rd_in,
  input  logic              exe_br_taken_in,
  input  logic              mem_l1d_req_val_in,
  input  logic              mem_l1d_ack_in,
  output logic              if_enb_out,
  output logic              dec_enb_out,
  output logic              exe_enb_out,
  output logic              mem_enb_out,
  output logic              wb_enb_out,
  output logic              if_kill_out,
  output logic              dec_kill_out,
  output logic [1:0]        state_out,
  output logic [PERF_W-1:0] perf_fetch_cnt_out,
  output logic [PERF_W-1:0] perf_luse_cnt_out,
  output logic [PERF_W-1:0] perf_lsu_cnt_out,
  output logic [PERF_W-1:0] perf_flush_cnt_out
);

  pipe_state_e state_q;
  pipe_state_e state_d;

  logic luse_haz;
  logic l1d_hold;
  logic run_go;
  logic br_evt;
  logic luse_evt;
  logic fetch_evt;

  core_luse_det u_luse_det (
    .haz_cmd (dec_haz_cmd_in),
    .rs1     (dec_rs1_in),
    .rs2     (dec_rs2_in),
    .exe_rd  (exe_rd_in),
    .exe_ld  (exe_ld_in),
    .exe_val (exe_val_in),
    .hazard  (luse_haz)
  );

  // A request acked in the same cycle completes without freezing anything.
  assign l1d_hold = mem_l1d_req_val_in & ~mem_l1d_ack_in;

  // RUN cycles that are not frozen by the data cache; the three events below
  // are mutually exclusive in priority order and also feed the counters.
  assign run_go    = ~rst & (state_q == ST_RUN) & ~l1d_hold;
  assign br_evt    = run_go & exe_val_in & exe_br_taken_in;
  assign luse_evt  = run_go & ~br_evt & luse_haz;
  assign fetch_evt = run_go & ~br_evt & ~luse_haz & ~l1i_ack_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    if_enb_out   = 1'b0;
    dec_enb_out  = 1'b0;
    exe_enb_out  = 1'b0;
    mem_enb_out  = 1'b0;
    wb_enb_out   = 1'b0;
    if_kill_out  = 1'b0;
    dec_kill_out = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (l1d_hold) begin
          // Whole pipe holds; a branch in EXE is re-presented after the wait.
          state_d = ST_LSU_WAIT;
        end else if (br_evt) begin
          // Both younger instructions are wrong-path. If a fetch is still in
          // flight its response belongs to the old path and must be dropped.
          if_enb_out   = 1'b1;
          dec_enb_out  = 1'b1;
          exe_enb_out  = 1'b1;
          mem_enb_out  = 1'b1;
          wb_enb_out   = 1'b1;
          if_kill_out  = 1'b1;
          dec_kill_out = 1'b1;
          state_d      = l1i_busy_in ? ST_DROP : ST_RUN;
        end else if (luse_evt) begin
          // DEC holds its instruction; the load moves on, so the hazard
          // clears by itself after exactly one bubble.
          exe_enb_out  = 1'b1;
          mem_enb_out  = 1'b1;
          wb_enb_out   = 1'b1;
          dec_kill_out = 1'b1;
        end else if (fetch_evt) begin
          dec_enb_out  = 1'b1;
          exe_enb_out  = 1'b1;
          mem_enb_out  = 1'b1;
          wb_enb_out   = 1'b1;
          dec_kill_out = 1'b1;
        end else begin
          if_enb_out   = 1'b1;
          dec_enb_out  = 1'b1;
          exe_enb_out  = 1'b1;
          mem_enb_out  = 1'b1;
          wb_enb_out   = 1'b1;
        end
      end

      ST_LSU_WAIT: begin
        if (mem_l1d_ack_in) begin
          state_d = ST_RUN;
        end
      end

      ST_DROP: begin
        // The wrong-path response is discarded on arrival even if the data
        // cache is stalling; the drop then hands over to the lsu wait.
        if_kill_out = l1i_ack_in;
        if (!l1d_hold) begin
          dec_enb_out  = 1'b1;
          exe_enb_out  = 1'b1;
          mem_enb_out  = 1'b1;
          wb_enb_out   = 1'b1;
          dec_kill_out = 1'b1;
        end
        if (l1i_ack_in) begin
          state_d = l1d_hold ? ST_LSU_WAIT : ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Nothing may advance while reset is held, even though RUN is the reset state.
    if (rst) begin
      if_enb_out   = 1'b0;
      dec_enb_out  = 1'b0;
      exe_enb_out  = 1'b0;
      mem_enb_out  = 1'b0;
      wb_enb_out   = 1'b0;
      if_kill_out  = 1'b0;
      dec_kill_out = 1'b0;
    end
  end

  assign state_out = state_q;

`ifdef CORE_PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] fetch_cnt_q;
  logic [PERF_W-1:0] luse_cnt_q;
  logic [PERF_W-1:0] lsu_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  logic              lsu_evt;

  assign lsu_evt = (state_q == ST_LSU_WAIT);

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      luse_cnt_q  <= '0;
      lsu_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_evt && (fetch_cnt_q != CNT_MAX)) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
      end
      if (luse_evt && (luse_cnt_q != CNT_MAX)) begin
        luse_cnt_q <= luse_cnt_q + CNT_ONE;
      end
      if (lsu_evt && (lsu_cnt_q != CNT_MAX)) begin
        lsu_cnt_q <= lsu_cnt_q + CNT_ONE;
      end
      if (br_evt && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign perf_fetch_cnt_out = fetch_cnt_q;
  assign perf_luse_cnt_out  = luse_cnt_q;
  assign perf_lsu_cnt_out   = lsu_cnt_q;
  assign perf_flush_cnt_out = flush_cnt_q;
`else
  assign perf_fetch_cnt_out = '0;
  assign perf_luse_cnt_out  = '0;
  assign perf_lsu_cnt_out   = '0;
  assign perf_flush_cnt_out = '0;
`endif

endmodule
